// File: rtl/drain_fifo_fsm.sv
// drain_fifo_fsm: read-side controller for the HDMI line FIFO. Pops pixel words into a 2-entry skid
// buffer, feeds hdmi_core, and emits half_full/hsync/vsync refill pulses. Option: DRAIN_FIFO_UNDERFLOW_CNT_EN.
module drain_fifo_fsm #(
  parameter int HALF_FIFO_WORDS = 64,
  parameter int DATA_WIDTH      = 32,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                  Bus2IP_Clk,
  input  logic                  Bus2IP_Reset,
  input  logic                  start_drain,
  input  logic [31:0]           NUM_PIXELS_PER_LINE,
  input  logic [31:0]           NUM_LINES_PER_FRAME,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic [DATA_WIDTH-1:0] pix_data,
  output logic                  pix_valid,
  input  logic                  pix_ready,
  output logic                  pix_eol,
  output logic                  pix_eof,
  output logic                  half_full,
  output logic                  hsync,
  output logic                  vsync,
  output logic                  busy,
  output logic                  cfg_err,
  output logic                  underflow_err,
`ifdef DRAIN_FIFO_UNDERFLOW_CNT_EN
  output logic [15:0]           underflow_cnt,
`endif
  output logic [1:0]            dbg_state
);

  localparam int HW = $clog2(HALF_FIFO_WORDS);
  localparam int EW = DATA_WIDTH + 2;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [HW-1:0]        HW_ONE  = {{(HW-1){1'b0}}, 1'b1};

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACTIVE = 2'd1;
  localparam logic [1:0] S_FLUSH  = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]           state_q, state_d;
  logic [CNT_WIDTH-1:0] p_last_q, l_last_q, pix_cnt_q, line_cnt_q;
  logic [CNT_WIDTH-1:0] p_in, l_in;
  logic [HW-1:0]        half_cnt_q;
  logic                 infl_q, infl_eol_q, infl_eof_q;
  logic [EW-1:0]        s0_q, s1_q, in_word;
  logic [1:0]           skid_cnt_q;
  logic                 half_full_q, hsync_q, vsync_q, cfg_err_q, underflow_err_q;
  logic                 cfg_bad, pop, acc, line_end, frame_end, uf_cond;

  // Pixel port handshake: a word moves to hdmi_core in every cycle where pix_valid && pix_ready;
  // while pix_valid && !pix_ready the head entry (data, eol, eof) is held unchanged.
  assign p_in      = NUM_PIXELS_PER_LINE[CNT_WIDTH-1:0];
  assign l_in      = NUM_LINES_PER_FRAME[CNT_WIDTH-1:0];
  assign cfg_bad   = (p_in == '0) || (l_in == '0) || (p_in[HW-1:0] != '0);
  assign line_end  = (pix_cnt_q == p_last_q);
  assign frame_end = line_end && (line_cnt_q == l_last_q);
  assign pop       = (state_q == S_ACTIVE) && !fifo_empty && ((skid_cnt_q + {1'b0, infl_q}) < 2'd2);
  assign pix_valid = (skid_cnt_q != 2'd0);
  assign acc       = pix_valid && pix_ready;
  assign uf_cond   = (state_q == S_ACTIVE) && (skid_cnt_q == 2'd0) && !infl_q && fifo_empty && pix_ready;
  assign in_word   = {infl_eof_q, infl_eol_q, fifo_dout};

  assign fifo_rd_en    = pop;
  assign pix_data      = pix_valid ? s0_q[DATA_WIDTH-1:0] : '0;
  assign pix_eol       = pix_valid && s0_q[DATA_WIDTH];
  assign pix_eof       = pix_valid && s0_q[DATA_WIDTH+1];
  assign half_full     = half_full_q;
  assign hsync         = hsync_q;
  assign vsync         = vsync_q;
  assign busy          = (state_q != S_IDLE);
  assign cfg_err       = cfg_err_q;
  assign underflow_err = underflow_err_q;
  assign dbg_state     = state_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start_drain && !cfg_bad) state_d = S_ACTIVE;
      S_ACTIVE: if (pop && frame_end) state_d = S_FLUSH;
      S_FLUSH:  if ((skid_cnt_q == 2'd0) && !infl_q) state_d = S_DONE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Bus2IP_Clk) begin
    if (Bus2IP_Reset) begin
      state_q         <= S_IDLE;
      p_last_q        <= '0;
      l_last_q        <= '0;
      pix_cnt_q       <= '0;
      line_cnt_q      <= '0;
      half_cnt_q      <= '0;
      infl_q          <= 1'b0;
      infl_eol_q      <= 1'b0;
      infl_eof_q      <= 1'b0;
      s0_q            <= '0;
      s1_q            <= '0;
      skid_cnt_q      <= 2'd0;
      half_full_q     <= 1'b0;
      hsync_q         <= 1'b0;
      vsync_q         <= 1'b0;
      cfg_err_q       <= 1'b0;
      underflow_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      // The line-end pop never raises half_full: the filler's line increment already covers it.
      hsync_q     <= pop && line_end && !frame_end;
      vsync_q     <= pop && frame_end;
      half_full_q <= pop && !line_end && (half_cnt_q == '1);

      if ((state_q == S_IDLE) && start_drain) begin
        if (cfg_bad) begin
          cfg_err_q <= 1'b1;
        end else begin
          p_last_q   <= p_in - CNT_ONE;
          l_last_q   <= l_in - CNT_ONE;
          pix_cnt_q  <= '0;
          line_cnt_q <= '0;
          half_cnt_q <= '0;
        end
      end

      infl_q <= pop;
      if (pop) begin
        infl_eol_q <= line_end;
        infl_eof_q <= frame_end;
        if (line_end) begin
          pix_cnt_q  <= '0;
          half_cnt_q <= '0;
          if (!frame_end) line_cnt_q <= line_cnt_q + CNT_ONE;
        end else begin
          pix_cnt_q  <= pix_cnt_q + CNT_ONE;
          half_cnt_q <= half_cnt_q + HW_ONE;
        end
      end

      // Skid buffer: s0 is the head presented on the pixel port, s1 the second entry.
      case ({infl_q, acc})
        2'b10: begin
          if (skid_cnt_q == 2'd0) s0_q <= in_word;
          else                    s1_q <= in_word;
          skid_cnt_q <= skid_cnt_q + 2'd1;
        end
        2'b01: begin
          s0_q       <= s1_q;
          skid_cnt_q <= skid_cnt_q - 2'd1;
        end
        2'b11: begin
          if (skid_cnt_q == 2'd1) begin
            s0_q <= in_word;
          end else begin
            s0_q <= s1_q;
            s1_q <= in_word;
          end
        end
        default: ;
      endcase

      if (uf_cond) underflow_err_q <= 1'b1;
    end
  end

`ifdef DRAIN_FIFO_UNDERFLOW_CNT_EN
  logic [15:0] uf_cnt_q;
  assign underflow_cnt = uf_cnt_q;

  always_ff @(posedge Bus2IP_Clk) begin
    if (Bus2IP_Reset)                          uf_cnt_q <= 16'd0;
    else if (uf_cond && (uf_cnt_q != 16'hFFFF)) uf_cnt_q <= uf_cnt_q + 16'd1;
  end
`endif

endmodule

// File: tb/tb_drain_fifo_fsm.sv
// tb_drain_fifo_fsm: table-driven frame runs with randomized ready/empty traffic, checked against a
// pixel-index reference model, plus hand-written underflow and mid-frame reset sequences.
module tb_drain_fifo_fsm;
  localparam int H  = 64;
  localparam int DW = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          Bus2IP_Reset;
  logic          start_drain;
  logic [31:0]   NUM_PIXELS_PER_LINE, NUM_LINES_PER_FRAME;
  logic          fifo_empty, fifo_rd_en;
  logic [DW-1:0] fifo_dout;
  logic [DW-1:0] pix_data;
  logic          pix_valid, pix_ready, pix_eol, pix_eof;
  logic          half_full, hsync, vsync, busy, cfg_err, underflow_err;
  logic [1:0]    dbg_state;
`ifdef DRAIN_FIFO_UNDERFLOW_CNT_EN
  logic [15:0]   underflow_cnt;
`endif

  drain_fifo_fsm #(.HALF_FIFO_WORDS(H), .DATA_WIDTH(DW), .CNT_WIDTH(16)) dut (
    .Bus2IP_Clk(clk),
    .Bus2IP_Reset(Bus2IP_Reset),
    .start_drain(start_drain),
    .NUM_PIXELS_PER_LINE(NUM_PIXELS_PER_LINE),
    .NUM_LINES_PER_FRAME(NUM_LINES_PER_FRAME),
    .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en),
    .fifo_dout(fifo_dout),
    .pix_data(pix_data),
    .pix_valid(pix_valid),
    .pix_ready(pix_ready),
    .pix_eol(pix_eol),
    .pix_eof(pix_eof),
    .half_full(half_full),
    .hsync(hsync),
    .vsync(vsync),
    .busy(busy),
    .cfg_err(cfg_err),
    .underflow_err(underflow_err),
`ifdef DRAIN_FIFO_UNDERFLOW_CNT_EN
    .underflow_cnt(underflow_cnt),
`endif
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int vectors = 0;
  int errors  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  logic [31:0] seed;
  function automatic logic [31:0] word_of(input int i);
    return (32'(i) * 32'h9E3779B1) ^ seed;
  endfunction

  // ---------------- FIFO model (unbounded source, empty forced by driver) ----------------
  int   fifo_idx;
  logic fifo_clr;
  always @(posedge clk) begin
    if (fifo_clr) fifo_idx <= 0;
    else if (fifo_rd_en && !fifo_empty) begin
      fifo_dout <= word_of(fifo_idx);
      fifo_idx  <= fifo_idx + 1;
    end
  end

  // ---------------- reference model / monitor ----------------
  int   cur_p, cur_l;
  logic mon_en, mon_clr;
  int   n_pop, n_acc, n_hs, n_vs, n_hf, uf_model, prev_pop_n, cyc, eof_cyc, fall_cyc;
  logic prev_pop, prev_stall, prev_busy, busy_seen, rd_seen, started;
  logic [33:0] prev_pix, exp_pix;
  logic [2:0]  exp_pulse;

  always @(negedge clk) begin
    cyc++;
    if (mon_clr) begin
      n_pop = 0; n_acc = 0; n_hs = 0; n_vs = 0; n_hf = 0; uf_model = 0;
      prev_pop = 0; prev_pop_n = 0; prev_stall = 0; prev_busy = 0;
      busy_seen = 0; rd_seen = 0; started = 0; eof_cyc = 0; fall_cyc = 0;
    end else if (mon_en) begin
      // pulse for pop number n appears the cycle after that pop
      exp_pulse = 3'b000;
      if (prev_pop) begin
        if (prev_pop_n % cur_p == 0) exp_pulse = (prev_pop_n == cur_p * cur_l) ? 3'b100 : 3'b010;
        else if (prev_pop_n % H == 0) exp_pulse = 3'b001;
      end
      check("pulses{v,h,hf}", {vsync, hsync, half_full}, exp_pulse);
      n_vs += int'(vsync); n_hs += int'(hsync); n_hf += int'(half_full);

      if (started && (n_pop < cur_p * cur_l) && (n_pop == n_acc) && fifo_empty && pix_ready)
        uf_model++;

      if (prev_stall)
        check("stall_hold", {pix_valid, pix_eol, pix_eof, pix_data}, {1'b1, prev_pix});

      if (pix_valid && pix_ready) begin
        exp_pix = {((n_acc % cur_p) == cur_p - 1), (n_acc == cur_p * cur_l - 1), word_of(n_acc)};
        check("pixel{eol,eof,data}", {pix_eol, pix_eof, pix_data}, exp_pix);
        if (n_acc == cur_p * cur_l - 1) eof_cyc = cyc;
        n_acc++;
      end
      prev_stall = pix_valid && !pix_ready;
      prev_pix   = {pix_eol, pix_eof, pix_data};

      prev_pop = fifo_rd_en;
      if (fifo_rd_en) begin
        n_pop++;
        prev_pop_n = n_pop;
        rd_seen = 1;
        if (fifo_empty) check("rd_while_empty", 1, 0);
        if (n_pop > cur_p * cur_l) check("pop_past_frame", n_pop, cur_p * cur_l);
      end
      if ((n_pop - n_acc) > 2) check("outstanding_le2", n_pop - n_acc, 2);

      if (busy) busy_seen = 1;
      if (prev_busy && !busy) fall_cyc = cyc;
      prev_busy = busy;
      if (start_drain) started = 1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    Bus2IP_Reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 Bus2IP_Reset = 1'b0;
  endtask

  task automatic clear_model();
    mon_clr = 1'b1; fifo_clr = 1'b1;
    @(posedge clk);
    #1 mon_clr = 1'b0; fifo_clr = 1'b0;
  endtask

  task automatic drive_cycle(input int rmode, input int emode, input int k);
    case (rmode)
      0:       pix_ready = 1'b1;
      1:       pix_ready = ((k % 3) != 2);
      default: pix_ready = ($urandom_range(0, 3) != 0);
    endcase
    fifo_empty = (emode == 1) ? ($urandom_range(0, 4) == 0) : 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input int p, input int l);
    seed = $urandom;
    cur_p = p; cur_l = l;
    NUM_PIXELS_PER_LINE = p; NUM_LINES_PER_FRAME = l;
    mon_en = 1'b1;
    start_drain = 1'b1;
    @(posedge clk);
    #1 start_drain = 1'b0;
  endtask

  task automatic finish_frame(input int rmode, input int emode);
    int k;
    k = 0;
    while (k < 6000 && !(busy_seen && !busy)) begin
      drive_cycle(rmode, emode, k);
      k++;
    end
    if (k >= 6000) check("frame_timeout", 0, 1);
    pix_ready = 1'b1; fifo_empty = 1'b0;
    repeat (3) @(posedge clk);
    #1 mon_en = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_fifo_rd_en"}, fifo_rd_en, 0);
    check({tag, "_pix_valid"}, pix_valid, 0);
    check({tag, "_pix_data"}, pix_data, 0);
    check({tag, "_pix_eol_eof"}, {pix_eol, pix_eof}, 0);
    check({tag, "_half_full"}, half_full, 0);
    check({tag, "_hsync"}, hsync, 0);
    check({tag, "_vsync"}, vsync, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_cfg_err"}, cfg_err, 0);
    check({tag, "_underflow_err"}, underflow_err, 0);
    check({tag, "_state"}, dbg_state, 0);
`ifdef DRAIN_FIFO_UNDERFLOW_CNT_EN
    check({tag, "_underflow_cnt"}, underflow_cnt, 0);
`endif
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int p; int l; int rmode; int emode;
    bit exp_cfg; int exp_pix; int exp_hs; int exp_vs; int exp_hf;
  } vec_t;

  task automatic run_row(input vec_t v, input bit with_reset);
    if (with_reset) do_reset();
    clear_model();
    start_frame(v.p, v.l);
    if (v.exp_cfg) begin
      for (int k = 0; k < 20; k++) drive_cycle(0, 0, k);
      mon_en = 1'b0;
      check("cfg_err_set", cfg_err, 1);
      check("cfg_busy_never", busy_seen, 0);
      check("cfg_rd_never", rd_seen, 0);
    end else begin
      finish_frame(v.rmode, v.emode);
      check("cfg_err_clear", cfg_err, 0);
      check("pixels_out", n_acc, v.exp_pix);
      check("hsync_count", n_hs, v.exp_hs);
      check("vsync_count", n_vs, v.exp_vs);
      check("half_full_count", n_hf, v.exp_hf);
      check("underflow_vs_model", underflow_err, (uf_model != 0));
      check("busy_fall_after_eof", ((fall_cyc - eof_cyc) >= 2) && ((fall_cyc - eof_cyc) <= 3), 1);
      check("idle_after_frame", busy, 0);
    end
  endtask

  vec_t vecs[8];

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{128, 2, 0, 0, 1'b0, 256, 1, 1, 2};
    vecs[1] = '{128, 2, 1, 0, 1'b0, 256, 1, 1, 2};
    vecs[2] = '{100, 2, 0, 0, 1'b1,   0, 0, 0, 0};
    vecs[3] = '{128, 0, 0, 0, 1'b1,   0, 0, 0, 0};
    vecs[4] = '{ 64, 3, 0, 0, 1'b0, 192, 2, 1, 0};
    vecs[5] = '{192, 2, 2, 1, 1'b0, 384, 1, 1, 4};
    vecs[6] = '{ 64, 1, 2, 1, 1'b0,  64, 0, 1, 0};
    vecs[7] = '{  0, 4, 0, 0, 1'b1,   0, 0, 0, 0};

    Bus2IP_Reset = 1'b1; start_drain = 1'b0; pix_ready = 1'b1; fifo_empty = 1'b0;
    NUM_PIXELS_PER_LINE = 0; NUM_LINES_PER_FRAME = 0;
    mon_en = 1'b0; mon_clr = 1'b1; fifo_clr = 1'b1; seed = 0; cyc = 0;
    do_reset();
    clear_model();
    check_idle_outputs("reset");

    for (int i = 0; i < 8; i++) run_row(vecs[i], 1'b1);

    // FIFO starved for 10 cycles mid-line with the sink ready
    do_reset();
    clear_model();
    start_frame(128, 1);
    for (int k = 0; k < 2000 && n_acc < 30; k++) drive_cycle(0, 0, k);
    fifo_empty = 1'b1; pix_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1 fifo_empty = 1'b0;
    check("underflow_err_set", underflow_err, 1);
    check("underflow_model_hit", (uf_model >= 8) && (uf_model <= 10), 1);
`ifdef DRAIN_FIFO_UNDERFLOW_CNT_EN
    check("underflow_cnt", underflow_cnt, uf_model);
`endif
    finish_frame(0, 0);
    check("underflow_frame_pixels", n_acc, 128);

    // reset at pixel 70 of line 0, then a clean frame
    do_reset();
    clear_model();
    start_frame(128, 2);
    for (int k = 0; k < 2000 && n_pop < 70; k++) drive_cycle(0, 0, k);
    mon_en = 1'b0;
    Bus2IP_Reset = 1'b1;
    @(posedge clk);
    #1 Bus2IP_Reset = 1'b0;
    check_idle_outputs("midreset");
    run_row(vecs[0], 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
